// File: rtl/mem_access_unit_pkg.sv
// Shared constants and decode helpers for the M-stage data-access unit:
// address windows, load/store encodings, device select codes and ExcCodes.
package mem_access_unit_pkg;

  localparam logic [31:0] RAM_HI = 32'h0000_2fff;
  localparam logic [31:0] T0_LO  = 32'h0000_7f00;
  localparam logic [31:0] T0_HI  = 32'h0000_7f0b;
  localparam logic [31:0] T1_LO  = 32'h0000_7f10;
  localparam logic [31:0] T1_HI  = 32'h0000_7f1b;
  localparam logic [31:0] IG_LO  = 32'h0000_7f20;
  localparam logic [31:0] IG_HI  = 32'h0000_7f23;

  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LD_LH   = 3'b001;
  localparam logic [2:0] LD_LB   = 3'b010;
  localparam logic [2:0] LD_LW   = 3'b011;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SH   = 2'b01;
  localparam logic [1:0] ST_SB   = 2'b10;
  localparam logic [1:0] ST_SW   = 2'b11;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_T0   = 2'b01;
  localparam logic [1:0] SEL_T1   = 2'b10;
  localparam logic [1:0] SEL_IG   = 2'b11;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  typedef struct packed {
    logic ram;
    logic t0;
    logic t1;
    logic ig;
  } win_t;

  function automatic win_t decode_win(input logic [31:0] addr);
    win_t w;
    w.ram = (addr <= RAM_HI);
    w.t0  = (addr >= T0_LO) && (addr <= T0_HI);
    w.t1  = (addr >= T1_LO) && (addr <= T1_HI);
    w.ig  = (addr >= IG_LO) && (addr <= IG_HI);
    return w;
  endfunction

  function automatic logic [1:0] sel_code(input win_t w);
    logic [1:0] s;
    if (w.t0)      s = SEL_T0;
    else if (w.t1) s = SEL_T1;
    else if (w.ig) s = SEL_IG;
    else           s = SEL_NONE;
    return s;
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] stop, input logic [1:0] a);
    logic [3:0] be;
    case (stop)
      ST_SW:   be = 4'b1111;
      ST_SH:   be = a[1] ? 4'b1100 : 4'b0011;
      ST_SB:   be = 4'b0001 << a;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] stop, input logic [31:0] d);
    logic [31:0] r;
    case (stop)
      ST_SH:   r = {2{d[15:0]}};
      ST_SB:   r = {4{d[7:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_dm_ram.sv
// Data RAM: DM_WORDS x 32 with per-byte write enables and a registered read port.
module mem_access_unit_dm_ram #(
  parameter int DM_WORDS = 3072,
  localparam int AW = $clog2(DM_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DM_WORDS];

  // Byte-lane writes and synchronous read (read only when no lane is written)
  always_ff @(posedge clk) begin
    if (en) begin
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          mem_r[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
      if (we == 4'b0000) begin
        rdata <= mem_r[idx];
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-access unit: owns the data RAM, forwards timer/int-gen accesses
// over a req/ack bus and hands the raw word plus addr/load-op to the W stage.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DM_WORDS = 3072,
  parameter int TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic        m_exc_in,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic [2:0]  m_ldop,
  input  logic [1:0]  m_stop,
  output logic        m_stall,
  output logic [4:0]  st_exc,
  output logic [31:0] w_rdata,
  output logic [31:0] w_addr,
  output logic [2:0]  w_ldop,
  output logic        dev_req,
  output logic [1:0]  dev_sel,
  output logic        dev_we,
  output logic [31:0] dev_addr,
  output logic [31:0] dev_wdata,
  input  logic        dev_ack,
  input  logic [31:0] dev_rdata
);

  localparam int AW = $clog2(DM_WORDS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_DEV_WAIT = 1'b1;

  logic [0:0]    state_r;
  logic [CW-1:0] cnt_r;
  logic [31:0]   pend_addr_r;
  logic [2:0]    pend_ldop_r;
  logic          w_src_ram_r;
  logic [31:0]   w_rdata_r;

  win_t          win_s;
  logic          in_dev_s;
  logic          live_s;
  logic          st_fault_s;
  logic          idle_s;
  logic          ram_ld_s;
  logic          ram_st_s;
  logic          dev_go_s;
  logic          timeout_s;
  logic          done_s;
  logic [3:0]    be_s;
  logic [31:0]   lane_s;
  logic [31:0]   ram_rdata_s;

  // Window decode, store-fault detection and access classification
  always_comb begin
    win_s    = decode_win(m_addr);
    in_dev_s = win_s.t0 | win_s.t1 | win_s.ig;
    live_s   = m_valid & ~m_exc_in;
    idle_s   = (state_r == S_IDLE);
    if (m_stop == ST_NONE) begin
      st_fault_s = 1'b0;
    end else if ((m_stop == ST_SW) && (m_addr[1:0] != 2'b00)) begin
      st_fault_s = 1'b1;
    end else if ((m_stop == ST_SH) && m_addr[0]) begin
      st_fault_s = 1'b1;
    end else if (!(win_s.ram | in_dev_s)) begin
      st_fault_s = 1'b1;
    end else if ((win_s.t0 | win_s.t1) && (m_stop != ST_SW)) begin
      st_fault_s = 1'b1;
    end else if ((win_s.t0 | win_s.t1) && (m_addr[3:2] == 2'b10)) begin
      // timer count register is read-only
      st_fault_s = 1'b1;
    end else begin
      st_fault_s = 1'b0;
    end
    st_exc    = (live_s && st_fault_s) ? EXC_ADES : EXC_NONE;
    be_s      = byte_en(m_stop, m_addr[1:0]);
    lane_s    = lane_rep(m_stop, m_wdata);
    ram_ld_s  = live_s & idle_s & win_s.ram & (m_ldop != LD_NONE);
    ram_st_s  = live_s & idle_s & win_s.ram & (m_stop != ST_NONE) & ~st_fault_s;
    dev_go_s  = live_s & idle_s & in_dev_s &
                ((m_ldop != LD_NONE) | ((m_stop != ST_NONE) & ~st_fault_s));
    timeout_s = (state_r == S_DEV_WAIT) & ~dev_ack & (cnt_r == CNT_LAST);
    done_s    = (state_r == S_DEV_WAIT) & (dev_ack | timeout_s);
    m_stall   = dev_go_s | ((state_r == S_DEV_WAIT) & ~done_s);
  end

  mem_access_unit_dm_ram #(.DM_WORDS(DM_WORDS)) u_dm_ram (
    .clk   (clk),
    .en    ((ram_ld_s | ram_st_s) & reset),
    .we    (ram_st_s ? be_s : 4'b0000),
    .idx   (m_addr[AW+1:2]),
    .wdata (lane_s),
    .rdata (ram_rdata_s)
  );

  // RAM loads present the RAM's own read register; everything else uses w_rdata_r
  assign w_rdata = w_src_ram_r ? ram_rdata_s : w_rdata_r;

  // Access FSM, timeout counter, device bus and W-stage registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r     <= S_IDLE;
      cnt_r       <= '0;
      dev_req     <= 1'b0;
      dev_sel     <= SEL_NONE;
      dev_we      <= 1'b0;
      dev_addr    <= 32'h0000_0000;
      dev_wdata   <= 32'h0000_0000;
      pend_addr_r <= 32'h0000_0000;
      pend_ldop_r <= LD_NONE;
      w_addr      <= 32'h0000_0000;
      w_ldop      <= LD_NONE;
      w_rdata_r   <= 32'h0000_0000;
      w_src_ram_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          cnt_r <= '0;
          if (dev_go_s) begin
            state_r     <= S_DEV_WAIT;
            dev_req     <= 1'b1;
            dev_sel     <= sel_code(win_s);
            dev_we      <= (m_stop != ST_NONE);
            dev_addr    <= {m_addr[31:2], 2'b00};
            dev_wdata   <= lane_s;
            pend_addr_r <= m_addr;
            pend_ldop_r <= m_ldop;
            w_ldop      <= LD_NONE;
            w_rdata_r   <= 32'h0000_0000;
            w_src_ram_r <= 1'b0;
          end else begin
            w_addr      <= m_addr;
            w_ldop      <= live_s ? m_ldop : LD_NONE;
            w_rdata_r   <= 32'h0000_0000;
            w_src_ram_r <= ram_ld_s;
          end
        end
        S_DEV_WAIT: begin
          if (done_s) begin
            state_r     <= S_IDLE;
            cnt_r       <= '0;
            dev_req     <= 1'b0;
            w_addr      <= pend_addr_r;
            w_ldop      <= pend_ldop_r;
            w_rdata_r   <= (dev_ack && (pend_ldop_r != LD_NONE)) ? dev_rdata : 32'h0000_0000;
            w_src_ram_r <= 1'b0;
          end else begin
            cnt_r  <= cnt_r + CW'(1);
            w_ldop <= LD_NONE;
          end
        end
        default: begin
          state_r <= S_IDLE;
          dev_req <= 1'b0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

endmodule
